// File: rtl/ka_seq_mult_ctrl_131bit.sv
// Sequential Karatsuba GF(2) multiplier controller: one shared 66x66 clmul, three passes, overlap combine.
// Optional 16-bit completed-operation counter on op_cnt when KA_SEQ_OPCNT_EN is defined.
module ka_seq_mult_ctrl_131bit #(
    parameter int unsigned N = 131,
    parameter int unsigned H = 66
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a_in,
    input  logic [N-1:0]     b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4*H-2:0]   prod_out,
`ifdef KA_SEQ_OPCNT_EN
    output logic [15:0]      op_cnt,
`endif
    output logic             busy
);
    localparam int unsigned PW = 4*H - 1;
    localparam int unsigned SW = 2*H - 1;

    typedef logic [PW-1:0] prod_t;
    typedef enum logic [2:0] {IDLE, MUL_LO, MUL_HI, MUL_MID, COMB, DONE} state_t;

    state_t         state_q;
    logic [N-1:0]   a_q, b_q;
    logic [SW-1:0]  p_lo_q, p_hi_q, p_mid_q;
    prod_t          prod_q;
    logic           out_valid_q;

    logic [H-1:0]   a_lo, a_hi, b_lo, b_hi;
    logic [H-1:0]   mul_a, mul_b;
    logic [SW-1:0]  mul_r;
    prod_t          prod_d;

    assign a_lo = a_q[H-1:0];
    assign b_lo = b_q[H-1:0];
    assign a_hi = {{(2*H-N){1'b0}}, a_q[N-1:H]};
    assign b_hi = {{(2*H-N){1'b0}}, b_q[N-1:H]};

    // Operand mux feeding the single shared sub-multiplier
    always_comb begin
        mul_a = a_lo;
        mul_b = b_lo;
        case (state_q)
            MUL_HI: begin
                mul_a = a_hi;
                mul_b = b_hi;
            end
            MUL_MID: begin
                mul_a = a_lo ^ a_hi;
                mul_b = b_lo ^ b_hi;
            end
            default: ;
        endcase
    end

    always_comb begin
        mul_r = '0;
        for (int unsigned i = 0; i < H; i++) begin
            if (mul_b[i]) mul_r = mul_r ^ ({{(H-1){1'b0}}, mul_a} << i);
        end
    end

    assign prod_d = prod_t'(p_lo_q) ^ (prod_t'(p_mid_q) << H) ^ (prod_t'(p_hi_q) << (2*H));

    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign prod_out  = prod_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            p_lo_q      <= '0;
            p_hi_q      <= '0;
            p_mid_q     <= '0;
            prod_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a_in;
                        b_q     <= b_in;
                        state_q <= MUL_LO;
                    end
                end
                MUL_LO: begin
                    p_lo_q  <= mul_r;
                    state_q <= MUL_HI;
                end
                MUL_HI: begin
                    p_hi_q  <= mul_r;
                    state_q <= MUL_MID;
                end
                MUL_MID: begin
                    p_mid_q <= mul_r ^ p_lo_q ^ p_hi_q;
                    state_q <= COMB;
                end
                COMB: begin
                    prod_q      <= prod_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (in_valid) begin
                            a_q     <= a_in;
                            b_q     <= b_in;
                            state_q <= MUL_LO;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef KA_SEQ_OPCNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (out_valid_q && out_ready) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign op_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_ka_seq_mult_ctrl_131bit.sv
// Scoreboard bench for ka_seq_mult_ctrl_131bit: driver pushes reference products, monitor pops on output handshakes.
module tb_ka_seq_mult_ctrl_131bit;
    localparam int N  = 131;
    localparam int H  = 66;
    localparam int PW = 4*H - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  a_in, b_in;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] prod_out;
    logic          busy;
`ifdef KA_SEQ_OPCNT_EN
    logic [15:0]   op_cnt;
`endif

    ka_seq_mult_ctrl_131bit #(.N(N), .H(H)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod_out  (prod_out),
`ifdef KA_SEQ_OPCNT_EN
        .op_cnt    (op_cnt),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [PW-1:0] p;
        int unsigned   edge_n;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned acc_pend = 0;
    int unsigned hs_count = 0;

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Schoolbook carry-less product, coefficient by coefficient
    function automatic logic [PW-1:0] clmul_ref(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [PW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (a[i] & b[j]) r[i+j] = ~r[i+j];
        return r;
    endfunction

    function automatic logic [N-1:0] rnd_op();
        logic [159:0] t;
        logic [N-1:0] v;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        v = t[N-1:0];
        case ($urandom_range(0, 5))
            0: begin v = '0; v[$urandom_range(0, N-1)] = 1'b1; end
            1: v[H-1:0] = '0;
            2: v[N-1:H] = '0;
            default: ;
        endcase
        return v;
    endfunction

    task automatic step(input logic v, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic ordy, input logic [PW-1:0] e, output logic acc);
        @(negedge clk);
        in_valid  = v;
        a_in      = a;
        b_in      = b;
        out_ready = ordy;
        #1;
        acc = 1'b0;
        if (!rst && in_valid && in_ready) begin
            q.push_back('{p: e, edge_n: cyc + 1});
            acc_pend = 1;
            acc = 1'b1;
        end
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [PW-1:0] e);
        logic acc;
        int   k;
        acc = 1'b0;
        k = 0;
        while (!acc && k < 20) begin
            step(1'b1, a, b, 1'b1, e, acc);
            k++;
        end
        k = 0;
        while (q.size() > 0 && k < 20) begin
            step(1'b0, '0, '0, 1'b1, '0, acc);
            k++;
        end
        chk("op completes", PW'(q.size()), '0);
    endtask

    // Monitor: samples after the driver has settled inputs for the coming edge
    logic          prev_ov = 1'b0;
    logic          prev_hold = 1'b0;
    logic          prev_hs = 1'b0;
    logic [PW-1:0] held;
    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            prev_ov   = 1'b0;
            prev_hold = 1'b0;
            prev_hs   = 1'b0;
        end else begin
            logic busy_exp;
            exp_t e;
            busy_exp = (q.size() - acc_pend) > 0;
            chk("busy", PW'(busy), PW'(busy_exp));
            chk("in_ready", PW'(in_ready), PW'(!busy_exp || (out_valid && out_ready)));
            if (prev_hs) chk("out_valid falls after handshake", PW'(out_valid), '0);
            if (out_valid && !prev_ov) begin
                if (q.size() == 0) chk("unexpected out_valid", PW'(out_valid), '0);
                else chk("latency", PW'(cyc - q[0].edge_n), PW'(4));
            end
            if (prev_hold) begin
                chk("stall out_valid", PW'(out_valid), PW'(1));
                chk("stall prod_out", prod_out, held);
            end
            prev_hold = out_valid && !out_ready;
            held      = prod_out;
            prev_hs   = out_valid && out_ready;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("handshake without op", PW'(1), '0);
                end else begin
                    e = q.pop_front();
                    chk("prod_out", prod_out, e.p);
                    hs_count++;
                end
            end
`ifdef KA_SEQ_OPCNT_EN
            chk("op_cnt", PW'(op_cnt), PW'(16'(hs_count - (prev_hs ? 1 : 0))));
`endif
            prev_ov = out_valid;
        end
        acc_pend = 0;
    end

    initial begin
        #2000000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0]  a, b;
        logic [PW-1:0] e;
        logic          acc;
        int            k;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
        #1;
        chk("reset in_ready", PW'(in_ready), PW'(1));
        chk("reset out_valid", PW'(out_valid), '0);
        chk("reset busy", PW'(busy), '0);
        chk("reset prod_out", prod_out, '0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Directed products with hand-derived results
        a = '0; a[0] = 1'b1; e = '0; e[0] = 1'b1;
        run_op(a, a, e);
        a = '0; a[130] = 1'b1; e = '0; e[260] = 1'b1;
        run_op(a, a, e);
        a = '0; a[1:0] = 2'b11; e = '0; e[2:0] = 3'b101;
        run_op(a, a, e);
        a = '0; a[66] = 1'b1; a[0] = 1'b1; e = '0; e[132] = 1'b1; e[0] = 1'b1;
        run_op(a, a, e);

        // Back-pressure: stall 10 cycles, then accept a new op in the same edge as the output handshake
        a = rnd_op(); b = rnd_op();
        step(1'b1, a, b, 1'b0, clmul_ref(a, b), acc);
        chk("accept from idle", PW'(acc), PW'(1));
        k = 0;
        while (!out_valid && k < 20) begin
            step(1'b1, ~a, ~b, 1'b0, '0, acc);
            chk("no accept while busy", PW'(acc), '0);
            k++;
        end
        chk("out_valid reached", PW'(out_valid), PW'(1));
        repeat (10) step(1'b0, '0, '0, 1'b0, '0, acc);
        a = rnd_op(); b = rnd_op();
        step(1'b1, a, b, 1'b1, clmul_ref(a, b), acc);
        chk("back-to-back accept", PW'(acc), PW'(1));
        k = 0;
        while (q.size() > 0 && k < 20) begin
            step(1'b0, '0, '0, 1'b1, '0, acc);
            k++;
        end

        // Asynchronous reset while in MUL_HI
        a = rnd_op(); b = rnd_op();
        step(1'b1, a, b, 1'b1, clmul_ref(a, b), acc);
        step(1'b0, '0, '0, 1'b1, '0, acc);
        step(1'b0, '0, '0, 1'b1, '0, acc);
        rst = 1'b1;
        #1;
        chk("abort out_valid", PW'(out_valid), '0);
        chk("abort prod_out", prod_out, '0);
        chk("abort busy", PW'(busy), '0);
        chk("abort in_ready", PW'(in_ready), PW'(1));
        q.delete();
        acc_pend = 0;
        hs_count = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        a = rnd_op(); b = rnd_op();
        run_op(a, b, clmul_ref(a, b));

        // Randomised traffic with random valid and ready
        for (int i = 0; i < 1500; i++) begin
            logic v, r;
            v = ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 9) < 6);
            a = rnd_op(); b = rnd_op();
            step(v, a, b, r, clmul_ref(a, b), acc);
        end
        k = 0;
        while (q.size() > 0 && k < 40) begin
            step(1'b0, '0, '0, 1'b1, '0, acc);
            k++;
        end
        chk("drain", PW'(q.size()), '0);
        step(1'b0, '0, '0, 1'b1, '0, acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
